// File: rtl/mgmt_wb_pkg.sv
// Shared types and constants for the management-to-user-project Wishbone watchdog.
package mgmt_wb_pkg;

  // Watchdog transaction state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } wb_state_e;

  // Read data handed back to the CPU when the user project never answers.
  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Request fields latched when a transaction is accepted.
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  // Bundle the raw CPU-side request fields into a request record.
  function automatic wb_req_t wb_req_pack(
    input logic        we,
    input logic [3:0]  sel,
    input logic [31:0] adr,
    input logic [31:0] dat
  );
    wb_req_t req;
    req.we  = we;
    req.sel = sel;
    req.adr = adr;
    req.dat = dat;
    return req;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;

  // Count up on inc, stick at all-ones, zero on clr or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != COUNT_MAX)) begin
      count_r <= count_r + COUNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/mprj_wb_watchdog.sv
// Registered Wishbone stage between the management core and the user project.
// Each request is forwarded one cycle after it is seen; if the user side does
// not acknowledge in time the cycle is closed locally with a fixed error word
// and the event is recorded in the timeout statistics.
module mprj_wb_watchdog
  import mgmt_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEFAULT
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        mprj_wb_iena,
  input  logic        mprj_cyc_i,
  input  logic        mprj_stb_i,
  input  logic        mprj_we_i,
  input  logic [3:0]  mprj_sel_i,
  input  logic [31:0] mprj_adr_i,
  input  logic [31:0] mprj_dat_i,
  output logic        mprj_ack_o,
  output logic [31:0] mprj_dat_o,
  output logic        usr_cyc_o,
  output logic        usr_stb_o,
  output logic        usr_we_o,
  output logic [3:0]  usr_sel_o,
  output logic [31:0] usr_adr_o,
  output logic [31:0] usr_dat_o,
  input  logic        usr_ack_i,
  input  logic [31:0] usr_dat_i,
  output logic        to_irq,
  output logic [7:0]  to_count,
  output logic [31:0] to_last_adr,
  input  logic        to_clear
);

  // Counter value seen in the last allowed wait cycle; full 16-bit compare,
  // so the counter can never wrap before the timeout fires.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

  wb_state_e   state_r;
  wb_state_e   state_nxt_s;
  wb_req_t     req_r;
  wb_req_t     req_nxt_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic [31:0] resp_r;
  logic [31:0] resp_nxt_s;
  logic        usr_ack_s;
  logic        timeout_s;
  logic        usr_req_r;
  logic        ack_r;
  logic [31:0] to_last_adr_r;

  // A user ack only counts while the user-side inputs are enabled.
  assign usr_ack_s = usr_ack_i & mprj_wb_iena;

  // Next state, next request/counter/response values and timeout detection.
  // Master abort beats ack, and ack beats a same-cycle timeout.
  always_comb begin
    state_nxt_s = state_r;
    req_nxt_s   = req_r;
    cnt_nxt_s   = cnt_r;
    resp_nxt_s  = resp_r;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mprj_cyc_i && mprj_stb_i) begin
          state_nxt_s = ST_WAIT;
          req_nxt_s   = wb_req_pack(mprj_we_i, mprj_sel_i, mprj_adr_i, mprj_dat_i);
          cnt_nxt_s   = 16'h0000;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_nxt_s = cnt_r + 16'h0001;
        if (!mprj_cyc_i) begin
          state_nxt_s = ST_IDLE;
        end else if (usr_ack_s) begin
          state_nxt_s = ST_RESP;
          resp_nxt_s  = req_r.we ? 32'h0000_0000 : usr_dat_i;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_RESP;
          resp_nxt_s  = TIMEOUT_DATA;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, latched request, wait counter and response register.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_r <= ST_IDLE;
      req_r   <= '0;
      cnt_r   <= 16'h0000;
      resp_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      req_r   <= req_nxt_s;
      cnt_r   <= cnt_nxt_s;
      resp_r  <= resp_nxt_s;
    end
  end

  // Bus handshake flops, loaded from the next state so they line up with it.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      usr_req_r <= 1'b0;
      ack_r     <= 1'b0;
    end else begin
      usr_req_r <= (state_nxt_s == ST_WAIT);
      ack_r     <= (state_nxt_s == ST_RESP);
    end
  end

  // Address of the latest timed-out cycle; a clear wins over a same-cycle timeout.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      to_last_adr_r <= 32'h0000_0000;
    end else if (to_clear) begin
      to_last_adr_r <= 32'h0000_0000;
    end else if (timeout_s) begin
      to_last_adr_r <= req_r.adr;
    end else begin
      to_last_adr_r <= to_last_adr_r;
    end
  end

  sat_counter #(
    .WIDTH (8)
  ) u_to_count (
    .clk   (core_clk),
    .rst   (core_rst),
    .clr   (to_clear),
    .inc   (timeout_s),
    .count (to_count)
  );

  assign usr_cyc_o   = usr_req_r;
  assign usr_stb_o   = usr_req_r;
  assign usr_we_o    = req_r.we;
  assign usr_sel_o   = req_r.sel;
  assign usr_adr_o   = req_r.adr;
  assign usr_dat_o   = req_r.dat;
  assign mprj_ack_o  = ack_r;
  assign mprj_dat_o  = resp_r;
  assign to_last_adr = to_last_adr_r;
  // The interrupt marks the detection cycle itself, one cycle ahead of the
  // local ack, so it is taken straight from the timeout decision.
  assign to_irq      = timeout_s;

endmodule
